// File: rtl/reset_seq_pkg.sv
// Shared types and defaults for the PLL reset sequencer.
package reset_seq_pkg;

  // Sequencer state encoding; seq_state exposes these values directly.
  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    HOLD_MEM  = 2'd2,
    RUN       = 2'd3
  } seq_state_t;

  localparam int unsigned DEF_SYNC_STAGES        = 2;
  localparam int unsigned DEF_PLL_RST_CYCLES     = 8;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int unsigned DEF_LOCK_TIMEOUT       = 65535;
  localparam int unsigned DEF_HOLD_CYCLES        = 16;
  localparam int unsigned LOSS_CNT_W             = 8;

  // Counter width for a phase of n cycles; never below one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous level.
module bit_synchronizer #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // Shift the input through the flop chain; cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences PLL reset, lock qualification, memory and processor reset release.
module pll_reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES        = DEF_SYNC_STAGES,
  parameter int unsigned PLL_RST_CYCLES     = DEF_PLL_RST_CYCLES,
  parameter int unsigned LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned LOCK_TIMEOUT       = DEF_LOCK_TIMEOUT,
  parameter int unsigned HOLD_CYCLES        = DEF_HOLD_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pll_locked_async,
  input  logic                  btn_reset_async,
  output logic                  pll_rst,
  output logic                  mem_rst,
  output logic                  proc_rst,
  output logic [1:0]            seq_state,
  output logic [LOSS_CNT_W-1:0] lock_loss_count
);

  localparam int unsigned RST_W = cnt_width(PLL_RST_CYCLES);
  localparam int unsigned STB_W = cnt_width(LOCK_STABLE_CYCLES);
  localparam int unsigned TMO_W = cnt_width(LOCK_TIMEOUT);
  localparam int unsigned HLD_W = cnt_width(HOLD_CYCLES);

  localparam logic [RST_W-1:0] RST_LAST = RST_W'(PLL_RST_CYCLES - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [HLD_W-1:0] HLD_LAST = HLD_W'(HOLD_CYCLES - 1);
  localparam logic [LOSS_CNT_W-1:0] LOSS_MAX = '1;

  logic locked_s;
  logic btn_s;

  seq_state_t            state_q, state_d;
  logic [RST_W-1:0]      rst_cnt_q, rst_cnt_d;
  logic [STB_W-1:0]      stable_cnt_q, stable_cnt_d;
  logic [TMO_W-1:0]      timeout_cnt_q, timeout_cnt_d;
  logic [HLD_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;

  bit_synchronizer #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked_async),
    .q     (locked_s)
  );

  bit_synchronizer #(.STAGES(SYNC_STAGES)) u_btn_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_reset_async),
    .q     (btn_s)
  );

  // Next-state and counter logic; the button overrides everything except loss counting.
  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    stable_cnt_d  = stable_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    hold_cnt_d    = hold_cnt_q;
    loss_cnt_d    = loss_cnt_q;

    unique case (state_q)
      PLL_RESET: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
        end else begin
          rst_cnt_d = rst_cnt_q + RST_W'(1);
        end
      end
      WAIT_LOCK: begin
        if (locked_s && (stable_cnt_q == STB_LAST)) begin
          state_d = HOLD_MEM;
        end else if (timeout_cnt_q == TMO_LAST) begin
          state_d = PLL_RESET;
        end else begin
          stable_cnt_d  = locked_s ? (stable_cnt_q + STB_W'(1)) : '0;
          timeout_cnt_d = timeout_cnt_q + TMO_W'(1);
        end
      end
      HOLD_MEM: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
        end else if (hold_cnt_q == HLD_LAST) begin
          state_d = RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + HLD_W'(1);
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
        end
      end
    endcase

    // Lock loss after qualification is counted even when the button wins.
    if (!locked_s && ((state_q == HOLD_MEM) || (state_q == RUN)) && (loss_cnt_q != LOSS_MAX)) begin
      loss_cnt_d = loss_cnt_q + LOSS_CNT_W'(1);
    end

    if (btn_s) begin
      state_d = PLL_RESET;
    end

    // Every phase starts from zero; a held button keeps PLL_RESET pinned at its start.
    if (btn_s || (state_d != state_q)) begin
      rst_cnt_d     = '0;
      stable_cnt_d  = '0;
      timeout_cnt_d = '0;
      hold_cnt_d    = '0;
    end
  end

  // State, counters and reset outputs, all updated on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= PLL_RESET;
      rst_cnt_q     <= '0;
      stable_cnt_q  <= '0;
      timeout_cnt_q <= '0;
      hold_cnt_q    <= '0;
      loss_cnt_q    <= '0;
      pll_rst       <= 1'b1;
      mem_rst       <= 1'b1;
      proc_rst      <= 1'b1;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      stable_cnt_q  <= stable_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      loss_cnt_q    <= loss_cnt_d;
      pll_rst       <= (state_d == PLL_RESET);
      mem_rst       <= (state_d == PLL_RESET) || (state_d == WAIT_LOCK);
      proc_rst      <= (state_d != RUN);
    end
  end

  assign seq_state       = state_q;
  assign lock_loss_count = loss_cnt_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Table-driven bench for pll_reset_sequencer with a scoreboard of expected observations.
module tb_pll_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_locked_async;
  logic       btn_reset_async;
  logic       pll_rst;
  logic       mem_rst;
  logic       proc_rst;
  logic [1:0] seq_state;
  logic [7:0] lock_loss_count;

  typedef struct packed {
    logic [1:0] st;
    logic       pll;
    logic       mem;
    logic       proc;
    logic [7:0] cnt;
  } obs_t;

  typedef struct packed {
    logic       lock;
    logic       btn;
    logic [7:0] n;
    obs_t       exp;
  } vec_t;

  vec_t  vecs[$];
  string tags[$];
  obs_t  exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .SYNC_STAGES        (2),
    .PLL_RST_CYCLES     (3),
    .LOCK_STABLE_CYCLES (8),
    .LOCK_TIMEOUT       (32),
    .HOLD_CYCLES        (4)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pll_locked_async (pll_locked_async),
    .btn_reset_async  (btn_reset_async),
    .pll_rst          (pll_rst),
    .mem_rst          (mem_rst),
    .proc_rst         (proc_rst),
    .seq_state        (seq_state),
    .lock_loss_count  (lock_loss_count)
  );

  // Expected outputs follow directly from the state: 0 all high, 1 mem+proc, 2 proc, 3 none.
  function automatic obs_t mk_obs(input logic [1:0] st, input logic [7:0] cnt);
    obs_t o;
    o.st   = st;
    o.pll  = (st == 2'd0);
    o.mem  = (st == 2'd0) || (st == 2'd1);
    o.proc = (st != 2'd3);
    o.cnt  = cnt;
    return o;
  endfunction

  task automatic add(input string tag, input logic lock, input logic btn, input int n,
                     input logic [1:0] st, input int cnt);
    vec_t v;
    v.lock = lock;
    v.btn  = btn;
    v.n    = 8'(n);
    v.exp  = mk_obs(st, 8'(cnt));
    vecs.push_back(v);
    tags.push_back(tag);
  endtask

  // One-cycle lock drop in RUN followed by full requalification.
  task automatic add_drop(input int prev, input int nxt);
    add("drop_run",    1'b0, 1'b0, 1, 2'd3, prev);
    add("drop_sync",   1'b1, 1'b0, 1, 2'd3, prev);
    add("drop_wait",   1'b1, 1'b0, 1, 2'd1, nxt);
    add("relock_wait", 1'b1, 1'b0, 7, 2'd1, nxt);
    add("relock_mem",  1'b1, 1'b0, 1, 2'd2, nxt);
    add("relock_run",  1'b1, 1'b0, 4, 2'd3, nxt);
  endtask

  // Recovery after the sequencer was sent to PLL_RESET with lock held high.
  task automatic add_recover(input string tag, input int cnt);
    add({tag, "_rst"},  1'b1, 1'b0, 2, 2'd0, cnt);
    add({tag, "_wait"}, 1'b1, 1'b0, 1, 2'd1, cnt);
    add({tag, "_w7"},   1'b1, 1'b0, 7, 2'd1, cnt);
    add({tag, "_mem"},  1'b1, 1'b0, 1, 2'd2, cnt);
    add({tag, "_run"},  1'b1, 1'b0, 4, 2'd3, cnt);
  endtask

  task automatic check(input string tag);
    obs_t act;
    obs_t want;
    act = {seq_state, pll_rst, mem_rst, proc_rst, lock_loss_count};
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    want = exp_q.pop_front();
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got state=%0d pll_rst=%b mem_rst=%b proc_rst=%b loss=%0d, expected state=%0d pll_rst=%b mem_rst=%b proc_rst=%b loss=%0d",
               tag, act.st, act.pll, act.mem, act.proc, act.cnt,
               want.st, want.pll, want.mem, want.proc, want.cnt);
    end
  endtask

  task automatic expect_now(input string tag, input logic [1:0] st, input int cnt);
    exp_q.push_back(mk_obs(st, 8'(cnt)));
    check(tag);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n            = 1'b0;
    pll_locked_async = 1'b0;
    btn_reset_async  = 1'b0;

    // Power-up release with lock low, then first lock.
    add("pll_e1",      1'b0, 1'b0, 1, 2'd0, 0);
    add("pll_e2",      1'b0, 1'b0, 1, 2'd0, 0);
    add("wait_enter",  1'b0, 1'b0, 1, 2'd1, 0);
    add("lock_e0p8",   1'b1, 1'b0, 9, 2'd1, 0);
    add("mem_fall",    1'b1, 1'b0, 1, 2'd2, 0);
    add("hold_e0p12",  1'b1, 1'b0, 3, 2'd2, 0);
    add("proc_fall",   1'b1, 1'b0, 1, 2'd3, 0);
    // Three single-cycle lock drops in RUN.
    for (int k = 1; k <= 3; k++) add_drop(k - 1, k);
    // Button pulse in RUN: no loss counted.
    add("btn_y1",      1'b1, 1'b1, 1, 2'd3, 3);
    add("btn_y2",      1'b1, 1'b0, 1, 2'd3, 3);
    add("btn_y3",      1'b1, 1'b0, 1, 2'd0, 3);
    add_recover("btn", 3);
    // Button and lock drop together: PLL_RESET wins, loss still counted.
    add("bd_z1",       1'b0, 1'b1, 1, 2'd3, 3);
    add("bd_z2",       1'b1, 1'b0, 1, 2'd3, 3);
    add("bd_z3",       1'b1, 1'b0, 1, 2'd0, 4);
    add_recover("bd", 4);
    // Held button keeps the PLL_RESET counter cleared until it drops.
    add("hold_w2",     1'b1, 1'b1, 2, 2'd3, 4);
    add("hold_w3",     1'b1, 1'b1, 1, 2'd0, 4);
    add("hold_w6",     1'b1, 1'b1, 3, 2'd0, 4);
    add("hold_w10",    1'b1, 1'b0, 4, 2'd0, 4);
    add("hold_w11",    1'b1, 1'b0, 1, 2'd1, 4);
    add("hold_w18",    1'b1, 1'b0, 7, 2'd1, 4);
    add("hold_w19",    1'b1, 1'b0, 1, 2'd2, 4);
    add("hold_w23",    1'b1, 1'b0, 4, 2'd3, 4);
    // Lock lost for good: timeout after 32 WAIT_LOCK cycles, repeating.
    add("tmo_v3",      1'b0, 1'b0, 3,  2'd1, 5);
    add("tmo_v34",     1'b0, 1'b0, 31, 2'd1, 5);
    add("tmo_v35",     1'b0, 1'b0, 1,  2'd0, 5);
    add("tmo_v37",     1'b0, 1'b0, 2,  2'd0, 5);
    add("tmo_v38",     1'b0, 1'b0, 1,  2'd1, 5);
    add("tmo_v69",     1'b0, 1'b0, 31, 2'd1, 5);
    add("tmo_v70",     1'b0, 1'b0, 1,  2'd0, 5);
    add("tmo_v73",     1'b0, 1'b0, 3,  2'd1, 5);
    // Lock glitch in WAIT_LOCK restarts stable qualification.
    add("gl_g5",       1'b1, 1'b0, 5, 2'd1, 5);
    add("gl_g6",       1'b0, 1'b0, 1, 2'd1, 5);
    add("gl_g14",      1'b1, 1'b0, 8, 2'd1, 5);
    add("gl_g15",      1'b1, 1'b0, 1, 2'd1, 5);
    add("gl_g16",      1'b1, 1'b0, 1, 2'd2, 5);
    add("gl_g20",      1'b1, 1'b0, 4, 2'd3, 5);
    // Drive the loss counter to and past saturation.
    for (int k = 6; k <= 260; k++) add_drop((k - 1 > 255) ? 255 : k - 1, (k > 255) ? 255 : k);

    repeat (3) @(posedge clk);
    #1;
    expect_now("reset_state", 2'd0, 0);
    cycles(1);
    expect_now("reset_held", 2'd0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      pll_locked_async = vecs[i].lock;
      btn_reset_async  = vecs[i].btn;
      exp_q.push_back(vecs[i].exp);
      cycles(int'(vecs[i].n));
      check($sformatf("%s#%0d", tags[i], i));
    end

    // Asynchronous reset in HOLD_MEM aborts immediately, then a full sequence follows.
    pll_locked_async = 1'b0;
    cycles(1);
    pll_locked_async = 1'b1;
    cycles(10);
    expect_now("abort_pre", 2'd2, 255);
    #3;
    rst_n = 1'b0;
    #1;
    expect_now("abort_now", 2'd0, 0);
    @(posedge clk);
    #1;
    expect_now("abort_held", 2'd0, 0);
    rst_n = 1'b1;
    cycles(2);
    expect_now("abort_pll", 2'd0, 0);
    cycles(1);
    expect_now("abort_wait", 2'd1, 0);
    cycles(7);
    expect_now("abort_w7", 2'd1, 0);
    cycles(1);
    expect_now("abort_mem", 2'd2, 0);
    cycles(4);
    expect_now("abort_run", 2'd3, 0);

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: flip-flop depth of each input synchronizer; legal range >=2.
REQ-003 SHALL have parameter PLL_RST_CYCLES, default 8: width of the pll_rst pulse, in cycles.
REQ-004 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: number of consecutive synchronized-lock cycles required.
REQ-005 SHALL have parameter LOCK_TIMEOUT, default 65535: maximum number of cycles in WAIT_LOCK before the PLL is reset again.
REQ-006 SHALL have parameter HOLD_CYCLES, default 16: number of cycles mem_rst is released before proc_rst.
REQ-007 SHALL have these ports:
- clk  in  1  sequencer clock
- rst_n  in  1  async active-low reset
- pll_locked_async  in  1  PLL lock, asynchronous
- btn_reset_async  in  1  user reset request, active-high, asynchronous
- pll_rst  out  1  PLL reset request, active-high
- mem_rst  out  1  memory-domain reset, active-high
- proc_rst  out  1  processor reset, active-high
- seq_state  out  2  current state encoding
- lock_loss_count  out  8  saturating count of lock losses

Function
REQ-008 SHALL synchronize both async inputs through SYNC_STAGES flops to produce locked_s and btn_s.
REQ-009 SHALL implement states PLL_RESET=0, WAIT_LOCK=1, HOLD_MEM=2, RUN=3; seq_state SHALL equal the state register.
REQ-010 All outputs SHALL be registered and SHALL change on the same edge as the state.
- PLL_RESET: pll_rst=1, mem_rst=1, proc_rst=1.
- WAIT_LOCK: pll_rst=0, mem_rst=1, proc_rst=1.
- HOLD_MEM: pll_rst=0, mem_rst=0, proc_rst=1.
- RUN: pll_rst=0, mem_rst=0, proc_rst=0.
REQ-011 PLL_RESET SHALL last exactly PLL_RST_CYCLES cycles and then go to WAIT_LOCK with all counters cleared.
REQ-012 WAIT_LOCK stable counter:
- SHALL increment on each cycle with locked_s=1.
- SHALL clear on any cycle with locked_s=0.
- When locked_s=1 and the count equals LOCK_STABLE_CYCLES-1, the state SHALL go to HOLD_MEM.
REQ-013 WAIT_LOCK timeout counter:
- SHALL count every cycle spent in WAIT_LOCK.
- On reaching LOCK_TIMEOUT-1 without the stable condition, the state SHALL go to PLL_RESET.
- If the timeout and the stable condition occur on the same cycle, the stable condition SHALL win.
REQ-014 HOLD_MEM SHALL last exactly HOLD_CYCLES cycles and then go to RUN.
REQ-015 mem_rst SHALL fall exactly SYNC_STAGES+LOCK_STABLE_CYCLES-1 edges after the edge that first samples pll_locked_async high, provided lock stays high.
REQ-016 locked_s=0 in HOLD_MEM or RUN SHALL move the state to WAIT_LOCK on the next edge and increment lock_loss_count, saturating at 255.
REQ-017 btn_s=1 in any state SHALL move the state to PLL_RESET on the next edge; while btn_s stays high, the PLL_RESET counter SHALL stay cleared.
REQ-018 If btn_s=1 and a lock loss occur on the same cycle, the state SHALL go to PLL_RESET and lock_loss_count SHALL still increment.
REQ-019 The counter widths SHALL be $clog2 of their parameter; counters SHALL NOT wrap.

Reset
REQ-020 When rst_n=0, the block SHALL force immediately:
- state=PLL_RESET
- pll_rst=1, mem_rst=1, proc_rst=1
- all counters=0
- lock_loss_count=0
- synchronizer flops=0
REQ-021 After rst_n deasserts, the first PLL_RESET phase SHALL be a full PLL_RST_CYCLES long.
REQ-022 Reset asserted mid-sequence SHALL abort the sequence with no intermediate output glitch.

Structure
REQ-023 Package reset_seq_pkg SHALL hold:
- the state enum typedef (2 bits)
- the state encodings
- the default parameter constants
REQ-024 Sub-module bit_synchronizer (parameter STAGES, async active-low reset, reset value 0) SHALL be instantiated twice.

Verification
Verification uses SYNC_STAGES=2, PLL_RST_CYCLES=3, LOCK_STABLE_CYCLES=8, HOLD_CYCLES=4, LOCK_TIMEOUT=32.
REQ-025 Release rst_n with lock=0 -> pll_rst high for 3 cycles, then seq_state=1 and all resets still high.
REQ-026 Raise lock at edge e0 -> mem_rst falls at e0+9 and proc_rst falls at e0+13; seq_state goes 2 then 3.
REQ-027 In WAIT_LOCK, lock high for 5 cycles, low for 1, then high -> the stable count restarts and mem_rst falls 9 edges after the re-rise.
REQ-028 Lock never rises -> after 32 cycles in WAIT_LOCK the state returns to 0 and pll_rst pulses for 3 cycles; this repeats.
REQ-029 In RUN, drop lock for 1 cycle, three times -> proc_rst and mem_rst reassert each time and lock_loss_count=3; a preload near 255 saturates at 255.
REQ-030 Button pulse in RUN, and button plus lock drop on the same cycle -> state=0 with all resets high in both cases; the count increments only in the second case.
